decode_imm_controller: RTL
==========================

DECODE_IMM_CONTROLLER -- requirements
Module: decode_imm_controller

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 32, instruction/PC width; IMM_MAX_IN_WIDTH, default 25, immediate field width; IMM_FORMAT_SELECT, default 3, format code width.
REQ-002 SHALL have format code parameters: R_FORMAT 3'b000, I_FORMAT 3'b001, S_FORMAT 3'b010, U_FORMAT 3'b011, SB_FORMAT 3'b100, UJ_FORMAT 3'b101.
REQ-003 SHALL have ports:
- CLK  in  1  single clock; all state on rising edge.
- RST  in  1  synchronous, active-high reset.
- INS_VALID  in  1  fetch presents an instruction.
- INS_READY  out  1  controller can accept an instruction.
- INSTRUCTION  in  DATA_WIDTH  instruction word.
- PC_IN  in  DATA_WIDTH  PC of the instruction.
- FLUSH  in  1  discard all buffered instructions.
- OUT_VALID  out  1  decode-stage entry valid.
- OUT_READY  in  1  downstream consumes the entry.
- IMM_INPUT  out  IMM_MAX_IN_WIDTH  INSTRUCTION[31:7] of the head entry, for the immediate extender.
- IMM_FORMAT  out  IMM_FORMAT_SELECT  format select for the immediate extender.
- PC_OUT  out  DATA_WIDTH  PC of the head entry.
- ILLEGAL  out  1  head entry has an unrecognised opcode.
- ILLEGAL_COUNT  out  8  saturating count of illegal instructions delivered.

Function
REQ-004 SHALL define accept = INS_VALID & INS_READY and deliver = OUT_VALID & OUT_READY.
REQ-005 SHALL implement a two-entry in-order buffer: an output register plus one skid register.
REQ-006 SHALL implement states EMPTY, FULL and SKID.
- EMPTY: accept goes to FULL.
- FULL: accept & deliver stays FULL, with the new entry in the output register. Accept & !deliver goes to SKID, with the new entry in the skid register. !accept & deliver goes to EMPTY. Otherwise FULL holds.
- SKID: deliver goes to FULL, with the skid entry moved to the output register. Otherwise SKID holds.
REQ-007 SHALL drive INS_READY = 1 in EMPTY and FULL and 0 in SKID, decoded from the state register only.
REQ-008 SHALL drive OUT_VALID = 1 in FULL and SKID and 0 in EMPTY.
REQ-009 SHALL have 1-cycle latency: an instruction accepted in EMPTY at edge N appears on the outputs after edge N.
REQ-010 SHALL hold all outputs stable while OUT_VALID=1 and OUT_READY=0.
REQ-011 SHALL classify the format from INSTRUCTION[6:0] at accept time and store the result with the entry:
- 0110111 and 0010111: U.
- 1101111: UJ.
- 1100111, 0000011, 0010011, 1110011: I.
- 0100011: S.
- 1100011: SB.
- 0110011: R.
- Any other value: R with ILLEGAL=1.
REQ-012 SHALL also set ILLEGAL=1 whenever INSTRUCTION[1:0] != 2'b11.
REQ-013 SHALL increment ILLEGAL_COUNT on each deliver with ILLEGAL=1 and saturate at 255.
REQ-014 SHALL, on FLUSH, go to EMPTY at the next edge and drop both entries and any same-cycle input; FLUSH has priority over accept and deliver.
REQ-015 SHALL leave ILLEGAL_COUNT unaffected by FLUSH.
REQ-016 SHALL never overwrite an entry that has not been delivered and never reorder entries.

Reset
REQ-017 SHALL, when RST=1 at an edge, enter EMPTY.
REQ-018 SHALL, at reset, clear to zero: OUT_VALID, IMM_INPUT, IMM_FORMAT (R_FORMAT), PC_OUT, ILLEGAL, ILLEGAL_COUNT and the skid register.
REQ-019 SHALL have INS_READY=1 in the cycle after reset.
REQ-020 SHALL give RST priority over FLUSH, accept and deliver, including mid-operation in SKID.

Verification
REQ-021 SHALL pass these directed scenarios:
- Basic I-format: in EMPTY, accept 0x00500093 with PC 0x0, OUT_READY=1 -> next cycle OUT_VALID=1, IMM_FORMAT=001, IMM_INPUT=0x000A001, PC_OUT=0x0, ILLEGAL=0.
- All formats: back-to-back 0x12345037, 0x0020A423, 0x00000463, 0x0080006F, 0x00208033 with OUT_READY=1 -> IMM_FORMAT sequence 011, 010, 100, 101, 000, one per cycle. For the first, IMM_INPUT=0x02468A0.
- Backpressure: OUT_READY=0, accept A then B -> state SKID, INS_READY=0, outputs hold A. Then OUT_READY=1 -> A delivered, then B delivered, no loss or duplication.
- Flush: in SKID with INS_VALID=1 and FLUSH=1 -> next cycle OUT_VALID=0, INS_READY=1, and the input is not delivered.
- Illegal: deliver 0xFFFFFFFF 256 times, then 0x00000000 once -> ILLEGAL=1 each time, IMM_FORMAT=000, ILLEGAL_COUNT saturates at 255.
- Reset mid-operation: RST=1 in SKID -> next cycle OUT_VALID=0, INS_READY=1, ILLEGAL_COUNT=0.

Source files
------------

// File: rtl/decode_imm_controller_if.sv
// Fetch-to-decode bus of the immediate controller: instruction handshake in,
// decode-stage entry handshake out.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
// a source holding valid=1 keeps its payload stable until that transfer.
interface decode_imm_controller_if #(
    parameter int DATA_WIDTH        = 32,
    parameter int IMM_MAX_IN_WIDTH  = 25,
    parameter int IMM_FORMAT_SELECT = 3
);
    logic                         INS_VALID;
    logic                         INS_READY;
    logic [DATA_WIDTH-1:0]        INSTRUCTION;
    logic [DATA_WIDTH-1:0]        PC_IN;
    logic                         FLUSH;
    logic                         OUT_VALID;
    logic                         OUT_READY;
    logic [IMM_MAX_IN_WIDTH-1:0]  IMM_INPUT;
    logic [IMM_FORMAT_SELECT-1:0] IMM_FORMAT;
    logic [DATA_WIDTH-1:0]        PC_OUT;
    logic                         ILLEGAL;
    logic [7:0]                   ILLEGAL_COUNT;

    modport slave (
        input  INS_VALID, INSTRUCTION, PC_IN, FLUSH, OUT_READY,
        output INS_READY, OUT_VALID, IMM_INPUT, IMM_FORMAT, PC_OUT, ILLEGAL, ILLEGAL_COUNT
    );

    modport master (
        output INS_VALID, INSTRUCTION, PC_IN, FLUSH, OUT_READY,
        input  INS_READY, OUT_VALID, IMM_INPUT, IMM_FORMAT, PC_OUT, ILLEGAL, ILLEGAL_COUNT
    );
endinterface

// File: rtl/decode_imm_controller.sv
// Two-entry in-order buffer (output register + skid register) between fetch and
// decode that classifies the immediate format of each instruction as it is accepted.
module decode_imm_controller #(
    parameter int DATA_WIDTH        = 32,
    parameter int IMM_MAX_IN_WIDTH  = 25,
    parameter int IMM_FORMAT_SELECT = 3,
    parameter logic [IMM_FORMAT_SELECT-1:0] R_FORMAT  = 3'b000,
    parameter logic [IMM_FORMAT_SELECT-1:0] I_FORMAT  = 3'b001,
    parameter logic [IMM_FORMAT_SELECT-1:0] S_FORMAT  = 3'b010,
    parameter logic [IMM_FORMAT_SELECT-1:0] U_FORMAT  = 3'b011,
    parameter logic [IMM_FORMAT_SELECT-1:0] SB_FORMAT = 3'b100,
    parameter logic [IMM_FORMAT_SELECT-1:0] UJ_FORMAT = 3'b101
) (
    input  logic                     CLK,
    input  logic                     RST,
    decode_imm_controller_if.slave   bus,
    output logic [1:0]               dbg_state_o
);
    typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;

    state_t                       state_q;
    logic [IMM_MAX_IN_WIDTH-1:0]  out_imm_q, skid_imm_q;
    logic [IMM_FORMAT_SELECT-1:0] out_fmt_q, skid_fmt_q;
    logic [DATA_WIDTH-1:0]        out_pc_q, skid_pc_q;
    logic                         out_ill_q, skid_ill_q;
    logic [7:0]                   ill_cnt_q;

    logic [IMM_MAX_IN_WIDTH-1:0]  in_imm_d;
    logic [IMM_FORMAT_SELECT-1:0] in_fmt_d;
    logic                         in_ill_d;
    logic                         accept;
    logic                         deliver;

    always_comb begin
        in_fmt_d = R_FORMAT;
        in_ill_d = 1'b0;
        in_imm_d = bus.INSTRUCTION[IMM_MAX_IN_WIDTH+6:7];
        case (bus.INSTRUCTION[6:0])
            7'b0110111, 7'b0010111:                         in_fmt_d = U_FORMAT;
            7'b1101111:                                     in_fmt_d = UJ_FORMAT;
            7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011: in_fmt_d = I_FORMAT;
            7'b0100011:                                     in_fmt_d = S_FORMAT;
            7'b1100011:                                     in_fmt_d = SB_FORMAT;
            7'b0110011:                                     in_fmt_d = R_FORMAT;
            default:                                        in_ill_d = 1'b1;
        endcase
        if (bus.INSTRUCTION[1:0] != 2'b11) in_ill_d = 1'b1;
    end

    assign accept  = bus.INS_VALID & (state_q != SKID);
    assign deliver = (state_q != EMPTY) & bus.OUT_READY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= EMPTY;
            out_imm_q  <= '0;
            out_fmt_q  <= R_FORMAT;
            out_pc_q   <= '0;
            out_ill_q  <= 1'b0;
            skid_imm_q <= '0;
            skid_fmt_q <= R_FORMAT;
            skid_pc_q  <= '0;
            skid_ill_q <= 1'b0;
            ill_cnt_q  <= 8'd0;
        end else begin
            // A flushed head is discarded, not delivered, so it is not counted.
            if (!bus.FLUSH && deliver && out_ill_q && (ill_cnt_q != 8'hFF))
                ill_cnt_q <= ill_cnt_q + 8'd1;
            if (bus.FLUSH) begin
                state_q <= EMPTY;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (accept) begin
                            out_imm_q <= in_imm_d;
                            out_fmt_q <= in_fmt_d;
                            out_pc_q  <= bus.PC_IN;
                            out_ill_q <= in_ill_d;
                            state_q   <= FULL;
                        end
                    end
                    FULL: begin
                        if (accept && deliver) begin
                            out_imm_q <= in_imm_d;
                            out_fmt_q <= in_fmt_d;
                            out_pc_q  <= bus.PC_IN;
                            out_ill_q <= in_ill_d;
                        end else if (accept) begin
                            skid_imm_q <= in_imm_d;
                            skid_fmt_q <= in_fmt_d;
                            skid_pc_q  <= bus.PC_IN;
                            skid_ill_q <= in_ill_d;
                            state_q    <= SKID;
                        end else if (deliver) begin
                            state_q <= EMPTY;
                        end
                    end
                    SKID: begin
                        if (deliver) begin
                            out_imm_q <= skid_imm_q;
                            out_fmt_q <= skid_fmt_q;
                            out_pc_q  <= skid_pc_q;
                            out_ill_q <= skid_ill_q;
                            state_q   <= FULL;
                        end
                    end
                    default: state_q <= EMPTY;
                endcase
            end
        end
    end

    assign bus.INS_READY     = (state_q != SKID);
    assign bus.OUT_VALID     = (state_q != EMPTY);
    assign bus.IMM_INPUT     = out_imm_q;
    assign bus.IMM_FORMAT    = out_fmt_q;
    assign bus.PC_OUT        = out_pc_q;
    assign bus.ILLEGAL       = out_ill_q;
    assign bus.ILLEGAL_COUNT = ill_cnt_q;
    assign dbg_state_o       = state_q;
endmodule
